// File: rtl/param_dp_ram_pkg.sv
// Shared types for the parametrised dual-port RAM: read-during-write policy
// and clear-engine state encoding.
package param_dp_ram_pkg;

   typedef enum {WRITE_FIRST, READ_FIRST} rdw_mode_t;

   typedef enum logic {IDLE, CLEAR} clr_state_t;

endpackage

// File: rtl/param_dp_ram_core.sv
// Plain block storage: one byte-enabled write port and two registered,
// enable-gated read ports. No reset on the array or the read registers.
module param_dp_ram_core #(
   parameter int ADDRESSWIDTH = 6,
   parameter int BITWIDTH     = 16,
   parameter int DEPTH        = 34,
   parameter int BYTE_W       = 8,
   localparam int BE_W        = BITWIDTH / BYTE_W
) (
   input  logic                    clk,
   input  logic                    wr_en,
   input  logic [BE_W-1:0]         wr_be,
   input  logic [ADDRESSWIDTH-1:0] wr_addr,
   input  logic [BITWIDTH-1:0]     wr_data,
   input  logic                    rd_en_a,
   input  logic [ADDRESSWIDTH-1:0] rd_addr_a,
   output logic [BITWIDTH-1:0]     rd_data_a,
   input  logic                    rd_en_b,
   input  logic [ADDRESSWIDTH-1:0] rd_addr_b,
   output logic [BITWIDTH-1:0]     rd_data_b
);

   (* ram_style = "block" *) logic [BITWIDTH-1:0] mem [DEPTH];

   // Reads sample the array before this edge's write lands: old-word behaviour.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < BE_W; i++) begin
            if (wr_be[i]) begin
               mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
            end
         end
      end
      if (rd_en_a) begin
         rd_data_a <= mem[rd_addr_a];
      end
      if (rd_en_b) begin
         rd_data_b <= mem[rd_addr_b];
      end
   end

endmodule

// File: rtl/param_dp_ram.sv
// Simple-dual-port RAM with byte enables, registered reads with valid strobes,
// a zero-sweep clear engine and a selectable port-A read-during-write policy.
//
//  state | meaning
//  ------+----------------------------------------------------------
//  IDLE  | user traffic served; clr_req starts a sweep next cycle
//  CLEAR | writing zero to address cnt each cycle; user traffic dropped
module param_dp_ram
   import param_dp_ram_pkg::*;
#(
   parameter int        ADDRESSWIDTH = 6,
   parameter int        BITWIDTH     = 16,
   parameter int        DEPTH        = 34,
   parameter int        BYTE_W       = 8,
   parameter rdw_mode_t RDW_MODE     = WRITE_FIRST,
   parameter bit        INIT_CLEAR   = 1'b1,
   localparam int       BE_W         = BITWIDTH / BYTE_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr_req,
   output logic                    busy,
   input  logic                    we,
   input  logic [BE_W-1:0]         be,
   input  logic                    re_a,
   input  logic [ADDRESSWIDTH-1:0] a,
   input  logic [BITWIDTH-1:0]     din,
   output logic [BITWIDTH-1:0]     spo,
   output logic                    spo_vld,
   input  logic                    re_b,
   input  logic [ADDRESSWIDTH-1:0] dpra,
   output logic [BITWIDTH-1:0]     dpo,
   output logic                    dpo_vld
);

   localparam logic [ADDRESSWIDTH-1:0] LAST    = ADDRESSWIDTH'(DEPTH - 1);
   localparam logic [ADDRESSWIDTH:0]   DEPTH_W = (ADDRESSWIDTH + 1)'(DEPTH);
   localparam clr_state_t              RST_ST  = INIT_CLEAR ? CLEAR : IDLE;

   clr_state_t                state, state_nxt;
   logic [ADDRESSWIDTH-1:0]   cnt;
   logic                      clr_we, user_en;
   logic                      in_a, in_b, wr_user, rd_a, rd_b;
   logic                      core_wr_en;
   logic [BE_W-1:0]           core_wr_be;
   logic [ADDRESSWIDTH-1:0]   core_wr_addr;
   logic [BITWIDTH-1:0]       core_wr_data;
   logic [BITWIDTH-1:0]       core_a, core_b;
   logic                      a_zero_q, b_zero_q, a_byp_q;
   logic [BE_W-1:0]           byp_be_q;
   logic [BITWIDTH-1:0]       byp_din_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RST_ST;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clr_req) state_nxt = CLEAR;
         CLEAR:   if (cnt == LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state == CLEAR);
      clr_we  = (state == CLEAR);
      user_en = (state == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr_we) begin
         cnt <= (cnt == LAST) ? '0 : cnt + ADDRESSWIDTH'(1);
      end
   end

   assign in_a    = ({1'b0, a} < DEPTH_W);
   assign in_b    = ({1'b0, dpra} < DEPTH_W);
   assign wr_user = user_en && we && in_a && (|be);
   assign rd_a    = user_en && re_a && in_a;
   assign rd_b    = user_en && re_b && in_b;

   // The sweep owns the write port whenever it runs.
   always_comb begin
      core_wr_en   = clr_we || wr_user;
      core_wr_be   = clr_we ? '1 : be;
      core_wr_addr = clr_we ? cnt : a;
      core_wr_data = clr_we ? '0 : din;
   end

   param_dp_ram_core #(
      .ADDRESSWIDTH (ADDRESSWIDTH),
      .BITWIDTH     (BITWIDTH),
      .DEPTH        (DEPTH),
      .BYTE_W       (BYTE_W)
   ) u_core (
      .clk       (clk),
      .wr_en     (core_wr_en),
      .wr_be     (core_wr_be),
      .wr_addr   (core_wr_addr),
      .wr_data   (core_wr_data),
      .rd_en_a   (rd_a),
      .rd_addr_a (a),
      .rd_data_a (core_a),
      .rd_en_b   (rd_b),
      .rd_addr_b (dpra),
      .rd_data_b (core_b)
   );

   // Zero flags cover both reset and out-of-range reads, since the core
   // read registers carry no reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spo_vld   <= 1'b0;
         a_zero_q  <= 1'b1;
         a_byp_q   <= 1'b0;
         byp_be_q  <= '0;
         byp_din_q <= '0;
      end else begin
         spo_vld <= user_en && re_a;
         if (user_en && re_a) begin
            a_zero_q  <= !in_a;
            a_byp_q   <= (RDW_MODE == WRITE_FIRST) && wr_user;
            byp_be_q  <= be;
            byp_din_q <= din;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dpo_vld  <= 1'b0;
         b_zero_q <= 1'b1;
      end else begin
         dpo_vld <= user_en && re_b;
         if (user_en && re_b) begin
            b_zero_q <= !in_b;
         end
      end
   end

   // Write-first: overlay the written lanes on the old word read by the core.
   always_comb begin
      spo = '0;
      if (!a_zero_q) begin
         for (int i = 0; i < BE_W; i++) begin
            spo[i*BYTE_W +: BYTE_W] = (a_byp_q && byp_be_q[i]) ?
                                      byp_din_q[i*BYTE_W +: BYTE_W] :
                                      core_a[i*BYTE_W +: BYTE_W];
         end
      end
   end

   assign dpo = b_zero_q ? '0 : core_b;

endmodule

// File: tb/tb_param_dp_ram.sv
// Scoreboard bench: a write-first and a read-first instance share stimulus;
// expectations from a behavioural model are queued per cycle and checked.
module tb_param_dp_ram;
   import param_dp_ram_pkg::*;

   localparam int DEPTH = 34;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clr_req = 1'b0, we = 1'b0, re_a = 1'b0, re_b = 1'b0;
   logic [1:0]  be = '0;
   logic [5:0]  a = '0, dpra = '0;
   logic [15:0] din = '0;
   logic        busy, spo_vld, dpo_vld, busy_rf, spo_vld_rf, dpo_vld_rf;
   logic [15:0] spo, dpo, spo_rf, dpo_rf;

   always #5 clk = ~clk;

   param_dp_ram #(.ADDRESSWIDTH(6), .BITWIDTH(16), .DEPTH(DEPTH), .BYTE_W(8),
                  .RDW_MODE(WRITE_FIRST), .INIT_CLEAR(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy), .we(we), .be(be),
      .re_a(re_a), .a(a), .din(din), .spo(spo), .spo_vld(spo_vld),
      .re_b(re_b), .dpra(dpra), .dpo(dpo), .dpo_vld(dpo_vld));

   param_dp_ram #(.ADDRESSWIDTH(6), .BITWIDTH(16), .DEPTH(DEPTH), .BYTE_W(8),
                  .RDW_MODE(READ_FIRST), .INIT_CLEAR(1'b1)) dut_rf (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_rf), .we(we), .be(be),
      .re_a(re_a), .a(a), .din(din), .spo(spo_rf), .spo_vld(spo_vld_rf),
      .re_b(re_b), .dpra(dpra), .dpo(dpo_rf), .dpo_vld(dpo_vld_rf));

   typedef struct packed {
      logic        vld;
      logic [15:0] wf;
      logic [15:0] rf;
      logic        bvld;
      logic [15:0] b;
      logic        busy;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0, n_errors = 0;
   logic [15:0] m_mem [DEPTH];
   int          m_left = 0;
   logic [15:0] m_wf = '0, m_rf = '0, m_b = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                         input logic [1:0] bb);
      merge = old;
      for (int i = 0; i < 2; i++) if (bb[i]) merge[i*8 +: 8] = nw[i*8 +: 8];
   endfunction

   task automatic drive(input logic we_i, input logic [1:0] be_i, input logic re_a_i,
                        input logic [5:0] a_i, input logic [15:0] din_i,
                        input logic re_b_i, input logic [5:0] dpra_i, input logic clr_i);
      exp_t        e;
      logic [15:0] old;
      we = we_i; be = be_i; re_a = re_a_i; a = a_i; din = din_i;
      re_b = re_b_i; dpra = dpra_i; clr_req = clr_i;
      e = '0;
      if (m_left == 0) begin
         if (re_a_i) begin
            e.vld = 1'b1;
            if (int'(a_i) < DEPTH) begin
               old  = m_mem[a_i];
               m_rf = old;
               m_wf = we_i ? merge(old, din_i, be_i) : old;
            end else begin
               m_rf = '0;
               m_wf = '0;
            end
         end
         if (re_b_i) begin
            e.bvld = 1'b1;
            m_b = (int'(dpra_i) < DEPTH) ? m_mem[dpra_i] : 16'h0;
         end
         if (we_i && int'(a_i) < DEPTH) m_mem[a_i] = merge(m_mem[a_i], din_i, be_i);
         if (clr_i) m_left = DEPTH;
      end else begin
         m_mem[DEPTH - m_left] = '0;
         m_left--;
      end
      e.wf = m_wf; e.rf = m_rf; e.b = m_b; e.busy = (m_left != 0);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("spo_vld", {31'b0, spo_vld}, {31'b0, e.vld});
      chk("spo_wf", {16'b0, spo}, {16'b0, e.wf});
      chk("spo_vld_rf", {31'b0, spo_vld_rf}, {31'b0, e.vld});
      chk("spo_rf", {16'b0, spo_rf}, {16'b0, e.rf});
      chk("dpo_vld", {31'b0, dpo_vld}, {31'b0, e.bvld});
      chk("dpo", {16'b0, dpo}, {16'b0, e.b});
      chk("dpo_rf", {16'b0, dpo_rf}, {16'b0, e.b});
      chk("busy", {31'b0, busy}, {31'b0, e.busy});
      chk("busy_rf", {31'b0, busy_rf}, {31'b0, e.busy});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 1'b0);
   endtask

   task automatic wr(input logic [5:0] ad, input logic [15:0] d, input logic [1:0] bb);
      drive(1'b1, bb, 1'b0, ad, d, 1'b0, 6'd0, 1'b0);
   endtask

   task automatic rd(input logic [5:0] ad_a, input logic [5:0] ad_b);
      drive(1'b0, 2'b00, 1'b1, ad_a, 16'h0, 1'b1, ad_b, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      we = 1'b0; be = '0; re_a = 1'b0; re_b = 1'b0; a = '0; dpra = '0; din = '0; clr_req = 1'b0;
      #1;
      chk("rst_spo", {16'b0, spo}, 32'h0);
      chk("rst_spo_rf", {16'b0, spo_rf}, 32'h0);
      chk("rst_dpo", {16'b0, dpo}, 32'h0);
      chk("rst_spo_vld", {31'b0, spo_vld}, 32'h0);
      chk("rst_dpo_vld", {31'b0, dpo_vld}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h1);
      sb.delete();
      m_left = DEPTH; m_wf = '0; m_rf = '0; m_b = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rel_busy", {31'b0, busy}, 32'h1);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'hDEAD;
      #2;
      do_reset();
      idle(DEPTH);
      rd(6'd5, 6'd33);
      chk("t1_spo", {16'b0, spo}, 32'h0);
      rd(6'd33, 6'd5);
      chk("t1_spo33", {16'b0, spo}, 32'h0);

      wr(6'd3, 16'hABCD, 2'b11);
      wr(6'd3, 16'h1234, 2'b01);
      rd(6'd3, 6'd3);
      chk("t2_spo", {16'b0, spo}, 32'hAB34);

      wr(6'd7, 16'h1111, 2'b11);
      drive(1'b1, 2'b11, 1'b1, 6'd7, 16'h2222, 1'b1, 6'd7, 1'b0);
      chk("t3_wf", {16'b0, spo}, 32'h2222);
      chk("t3_rf", {16'b0, spo_rf}, 32'h1111);
      chk("t3_dpo", {16'b0, dpo}, 32'h1111);

      wr(6'd6, 16'h5A5A, 2'b11);
      wr(6'd40, 16'hFFFF, 2'b11);
      rd(6'd40, 6'd6);
      chk("t5_spo", {16'b0, spo}, 32'h0);
      chk("t5_vld", {31'b0, spo_vld}, 32'h1);
      chk("t5_mem6", {16'b0, dpo}, 32'h5A5A);
      drive(1'b1, 2'b00, 1'b1, 6'd6, 16'h0F0F, 1'b0, 6'd0, 1'b0);

      for (int i = 0; i < DEPTH; i++) wr(6'(i), 16'(i * 16'h0101) ^ 16'h8000, 2'b11);
      drive(1'b0, 2'b00, 1'b1, 6'd12, 16'h0, 1'b1, 6'd20, 1'b1);
      for (int i = 0; i < DEPTH; i++)
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1,
               6'($urandom_range(0, 39)), 16'($urandom), 1'b1, 6'($urandom_range(0, 39)),
               1'($urandom_range(0, 1)));
      for (int i = 0; i < DEPTH; i++) begin
         rd(6'(i), 6'(DEPTH - 1 - i));
         chk("t4_dpo", {16'b0, dpo}, 32'h0);
      end

      for (int i = 0; i < 120; i++)
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               6'($urandom_range(0, 39)), 16'($urandom), 1'($urandom_range(0, 1)),
               6'($urandom_range(0, 39)), 1'($urandom_range(0, 59) == 0));
      idle(DEPTH);

      wr(6'd9, 16'hBEEF, 2'b11);
      drive(1'b0, 2'b00, 1'b1, 6'd9, 16'h0, 1'b1, 6'd9, 1'b1);
      idle(10);
      chk("t6_pre_spo", {16'b0, spo}, 32'hBEEF);
      do_reset();
      idle(DEPTH);
      rd(6'd9, 6'd0);
      chk("t6_spo", {16'b0, spo}, 32'h0);
      idle(1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
